// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard/stall controller
// Purpose: FSM state encoding, mul/div busy-counter sizing and the pipeline NOP encoding.
// Ports: none (package).
package hazard_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  localparam int MD_TIMEOUT_DEF = 64;
  localparam int MD_CNT_W       = $clog2(MD_TIMEOUT_DEF + 1);

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Busy-counter width for a given timeout; the counter must be able to hold the timeout value itself.
  function automatic int md_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter
// Purpose: counts cycles where inc is high, holding at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count enable), count (current value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush/bubble sequencing for the 5-stage RV32IM pipeline
// Purpose: load-use stalls, taken-redirect flushes and mul/div start/done/timeout handling.
// Ports: IF_ID_* / ID_EX_* hazard sources, EX_branch_taken, md_done from the mul/div unit;
//        stall_*/flush_*/bubble_EX_MEM pipeline controls, md_start/md_abort pulses,
//        md_timeout_err sticky flag, stall_cnt/flush_cnt saturating statistics.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_is_muldiv,
  input  logic             EX_branch_taken,
  input  logic             md_done,
  output logic             stall_IF,
  output logic             stall_ID_EX,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             bubble_EX_MEM,
  output logic             md_start,
  output logic             md_abort,
  output logic             md_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int CW = md_cnt_width(MD_TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  logic          err_q, err_d;
  logic          load_use;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((IF_ID_use_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                     (IF_ID_use_rs2 && (ID_EX_rd == IF_ID_rs2)));

  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    err_d         = err_q;
    stall_IF      = 1'b0;
    stall_ID_EX   = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    bubble_EX_MEM = 1'b0;
    md_start      = 1'b0;
    md_abort      = 1'b0;
    // Controls are forced quiet while reset is held, even though they are combinational.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (ID_EX_is_muldiv) begin
            md_start      = 1'b1;
            stall_IF      = 1'b1;
            stall_ID_EX   = 1'b1;
            bubble_EX_MEM = 1'b1;
            md_cnt_d      = CW'(1);
            state_d       = MD_BUSY;
          end else if (EX_branch_taken) begin
            // The redirect discards the dependent instruction anyway, so no stall is needed.
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end else if (load_use) begin
            // Hold IF/ID, insert one bubble into EX; the pair is re-checked next cycle.
            stall_IF    = 1'b1;
            flush_ID_EX = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_done) begin
            // Stalls drop this cycle so EX/MEM captures the mul/div result.
            md_cnt_d = '0;
            state_d  = IDLE;
          end else if (md_cnt_q == CW'(MD_TIMEOUT)) begin
            md_abort      = 1'b1;
            err_d         = 1'b1;
            bubble_EX_MEM = 1'b1;
            md_cnt_d      = '0;
            state_d       = IDLE;
          end else begin
            stall_IF      = 1'b1;
            stall_ID_EX   = 1'b1;
            bubble_EX_MEM = 1'b1;
            md_cnt_d      = md_cnt_q + 1'b1;
          end
        end
        default: begin
          md_cnt_d = '0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      err_q    <= err_d;
    end
  end

  assign md_timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_IF),
    .count (stall_cnt)
  );

  // flush_IF_ID is only raised for a taken redirect, so it marks exactly one event per redirect.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_IF_ID),
    .count (flush_cnt)
  );

endmodule
